// File: rtl/pointer_buffer_ctrl.sv
// Builds CSR row pointers from a stream of per-row counts, writes them into the
// pointer buffer, snapshots the whole buffer, then arbitrates single-entry reads.
module pointer_buffer_ctrl #(
  parameter int DWIDTH   = 8,
  parameter int AWIDTH   = 5,
  parameter int MEM_SIZE = 17
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       cnt_valid,
  output logic                       cnt_ready,
  input  logic [DWIDTH-1:0]          cnt_data,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow,
  output logic [DWIDTH*MEM_SIZE-1:0] ptr_all,
  output logic                       ptr_all_valid,
  output logic [AWIDTH-1:0]          pb_addr0,
  output logic                       pb_ce0,
  output logic                       pb_we0,
  output logic [DWIDTH-1:0]          pb_d0,
  input  logic [DWIDTH*MEM_SIZE-1:0] pb_q0,
  output logic [AWIDTH-1:0]          pb_addr1,
  output logic                       pb_ce1,
  output logic                       pb_we1,
  input  logic [DWIDTH-1:0]          pb_q1,
  input  logic [1:0]                 rd_req,
  input  logic [AWIDTH-1:0]          rd_addr_a,
  input  logic [AWIDTH-1:0]          rd_addr_b,
  output logic [1:0]                 rd_gnt,
  output logic [1:0]                 rd_valid,
  output logic [DWIDTH-1:0]          rd_data
);

  typedef enum logic [2:0] {IDLE, INIT, ACCUM, SNAP, CAPT} state_t;

  localparam logic [AWIDTH-1:0] LAST_ROW = AWIDTH'(MEM_SIZE - 2);
  localparam logic [AWIDTH-1:0] A_ONE    = AWIDTH'(1);

  state_t                      state_reg, state_next;
  logic [DWIDTH-1:0]           sum_reg;
  logic [AWIDTH-1:0]           row_reg;
  logic                        overflow_reg;
  logic                        ptr_all_valid_reg;
  logic                        done_reg;
  logic [DWIDTH*MEM_SIZE-1:0]  ptr_all_reg;
  logic                        last_b_reg;
  logic [1:0]                  rd_valid_reg;
  logic                        rd_oob_reg;

  logic                        hs;
  logic [DWIDTH:0]             nsum;
  logic [DWIDTH-1:0]           sum_sat;
  logic                        arb_en;
  logic [1:0]                  req_masked;
  logic [1:0]                  gnt;
  logic [AWIDTH-1:0]           gnt_addr;
  logic                        gnt_oob;

  // ---------------- build sequencer ----------------
  assign cnt_ready = (state_reg == ACCUM);
  assign hs        = cnt_valid & cnt_ready;
  assign nsum      = {1'b0, sum_reg} + {1'b0, cnt_data};
  // A saturated sum plus any count carries out again, so saturation is sticky.
  assign sum_sat   = nsum[DWIDTH] ? '1 : nsum[DWIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pb_ce0     = 1'b0;
    pb_we0     = 1'b0;
    pb_addr0   = '0;
    pb_d0      = '0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = INIT;
      end
      INIT: begin
        pb_ce0     = 1'b1;
        pb_we0     = 1'b1;
        state_next = ACCUM;
      end
      ACCUM: begin
        if (hs) begin
          pb_ce0   = 1'b1;
          pb_we0   = 1'b1;
          pb_addr0 = row_reg + A_ONE;
          pb_d0    = sum_sat;
          if (row_reg == LAST_ROW) state_next = SNAP;
        end
      end
      SNAP: begin
        pb_ce0     = 1'b1;
        state_next = CAPT;
      end
      CAPT: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg           <= '0;
      row_reg           <= '0;
      overflow_reg      <= 1'b0;
      ptr_all_valid_reg <= 1'b0;
      done_reg          <= 1'b0;
      ptr_all_reg       <= '0;
    end else begin
      done_reg <= (state_reg == CAPT);
      case (state_reg)
        IDLE: begin
          if (start) begin
            sum_reg           <= '0;
            row_reg           <= '0;
            overflow_reg      <= 1'b0;
            ptr_all_valid_reg <= 1'b0;
          end
        end
        ACCUM: begin
          if (hs) begin
            sum_reg <= sum_sat;
            row_reg <= row_reg + A_ONE;
            if (nsum[DWIDTH]) overflow_reg <= 1'b1;
          end
        end
        CAPT: begin
          ptr_all_reg       <= pb_q0;
          ptr_all_valid_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state_reg != IDLE);
  assign done          = done_reg;
  assign overflow      = overflow_reg;
  assign ptr_all       = ptr_all_reg;
  assign ptr_all_valid = ptr_all_valid_reg;

  // ---------------- port 1 round-robin arbiter ----------------
  assign arb_en     = (state_reg == IDLE) && ptr_all_valid_reg;
  assign req_masked = rd_req & {2{arb_en}};

  always_comb begin
    gnt = req_masked;
    // On a tie the requester that did not win last time is served.
    if (req_masked == 2'b11) gnt = last_b_reg ? 2'b01 : 2'b10;
  end

  assign gnt_addr = gnt[1] ? rd_addr_b : rd_addr_a;
  assign gnt_oob  = (int'(gnt_addr) >= MEM_SIZE);

  assign rd_gnt   = gnt;
  assign pb_ce1   = (|gnt) & ~gnt_oob;
  assign pb_addr1 = (|gnt) ? gnt_addr : '0;
  assign pb_we1   = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_reg   <= 1'b1;
      rd_valid_reg <= 2'b00;
      rd_oob_reg   <= 1'b0;
    end else begin
      rd_valid_reg <= gnt;
      rd_oob_reg   <= (|gnt) & gnt_oob;
      if (|gnt) last_b_reg <= gnt[1];
    end
  end

  assign rd_valid = rd_valid_reg;
  assign rd_data  = ((|rd_valid_reg) && !rd_oob_reg) ? pb_q1 : '0;

endmodule
